// File: rtl/seqdet_scheduler.sv
// Round-robin scheduler that streams each granted requester's word, MSB first,
// through an external 0110/1010 serial detector and reports a saturating hit count.
module seqdet_scheduler #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             det_rst,
  output logic             det_bit,
  input  logic             det_hit,
  output logic             done,
  output logic             result_id,
  output logic [CNT_W-1:0] hit_count,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, REPORT} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] word;
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] hits, hits_next;
  logic             cur_id;
  logic             prio1;
  logic             last_bit;

  assign last_bit  = (bit_idx == IDX_W'(WIDTH - 1));
  assign hits_next = (det_hit && (hits != '1)) ? hits + 1'b1 : hits;

  assign det_rst = reset || (state == CLEAR);
  assign det_bit = (state == SHIFT) ? word[WIDTH-1] : 1'b0;
  assign done    = (state == REPORT);
  assign busy    = (state != IDLE);

  // Grants are Mealy outputs of IDLE, suppressed while reset is asserted.
  always_comb begin
    next_state = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          if (req0 && (!req1 || !prio1)) begin
            gnt0 = 1'b1;
          end else if (req1) begin
            gnt1 = 1'b1;
          end
          if (req0 || req1) begin
            next_state = CLEAR;
          end
        end
      end
      CLEAR:   next_state = SHIFT;
      SHIFT:   if (last_bit) next_state = REPORT;
      REPORT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      word      <= '0;
      bit_idx   <= '0;
      hits      <= '0;
      cur_id    <= 1'b0;
      prio1     <= 1'b0;
      hit_count <= '0;
      result_id <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (gnt0) begin
            word   <= data0;
            cur_id <= 1'b0;
            prio1  <= 1'b1;
          end else if (gnt1) begin
            word   <= data1;
            cur_id <= 1'b1;
            prio1  <= 1'b0;
          end
        end
        CLEAR: begin
          bit_idx <= '0;
          hits    <= '0;
        end
        SHIFT: begin
          word    <= word << 1;
          bit_idx <= bit_idx + 1'b1;
          hits    <= hits_next;
          // Results load on the last shift edge so they are valid throughout REPORT.
          if (last_bit) begin
            hit_count <= hits_next;
            result_id <= cur_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seqdet_scheduler.sv
// Bench for seqdet_scheduler: behavioural detector and scheduler model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_seqdet_scheduler;

  localparam int WA = 8;
  localparam int CA = 4;
  localparam int WB = 16;
  localparam int CB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a = 1'b0, req0_a = 1'b0, req1_a = 1'b0;
  logic [WA-1:0] data0_a = '0, data1_a = '0;
  logic          gnt0_a, gnt1_a, det_rst_a, det_bit_a, det_hit_a, done_a, result_id_a, busy_a;
  logic [CA-1:0] hit_count_a;

  logic          rst_b = 1'b0, req0_b = 1'b0, req1_b = 1'b0;
  logic [WB-1:0] data0_b = '0, data1_b = '0;
  logic          gnt0_b, gnt1_b, det_rst_b, det_bit_b, det_hit_b, done_b, result_id_b, busy_b;
  logic [CB-1:0] hit_count_b;

  seqdet_scheduler #(.WIDTH(WA), .CNT_W(CA)) dut_a (
    .clk(clk), .reset(rst_a), .req0(req0_a), .req1(req1_a), .data0(data0_a), .data1(data1_a),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .det_rst(det_rst_a), .det_bit(det_bit_a), .det_hit(det_hit_a),
    .done(done_a), .result_id(result_id_a), .hit_count(hit_count_a), .busy(busy_a)
  );

  seqdet_scheduler #(.WIDTH(WB), .CNT_W(CB)) dut_b (
    .clk(clk), .reset(rst_b), .req0(req0_b), .req1(req1_b), .data0(data0_b), .data1(data1_b),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .det_rst(det_rst_b), .det_bit(det_bit_b), .det_hit(det_hit_b),
    .done(done_b), .result_id(result_id_b), .hit_count(hit_count_b), .busy(busy_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serial detector: overlapping 0110/1010 match over the last four bits since det_rst.
  logic [2:0] hist_a = '0, hist_b = '0;
  int seen_a = 0, seen_b = 0;
  always @(posedge clk) begin
    if (det_rst_a) begin
      hist_a <= '0; seen_a <= 0;
    end else begin
      hist_a <= {hist_a[1:0], det_bit_a};
      if (seen_a < 3) seen_a <= seen_a + 1;
    end
    if (det_rst_b) begin
      hist_b <= '0; seen_b <= 0;
    end else begin
      hist_b <= {hist_b[1:0], det_bit_b};
      if (seen_b < 3) seen_b <= seen_b + 1;
    end
  end
  assign det_hit_a = (seen_a >= 3) && ({hist_a, det_bit_a} == 4'b0110 || {hist_a, det_bit_a} == 4'b1010);
  assign det_hit_b = (seen_b >= 3) && ({hist_b, det_bit_b} == 4'b0110 || {hist_b, det_bit_b} == 4'b1010);

  function automatic int ideal_hits(input logic [31:0] w, input int width);
    int n = 0;
    logic [3:0] win;
    for (int i = 3; i < width; i++) begin
      win = {w[width-1-i+3], w[width-1-i+2], w[width-1-i+1], w[width-1-i]};
      if (win == 4'b0110 || win == 4'b1010) n++;
    end
    return n;
  endfunction

  function automatic int sat(input int n, input int cw);
    return (n > (1 << cw) - 1) ? (1 << cw) - 1 : n;
  endfunction

  // Scheduler model for dut_a: m_cnt = cycles since grant (0 = idle).
  int            m_cnt = 0;
  logic          m_prio1 = 1'b0;
  logic [WA-1:0] m_word = '0;
  logic          m_id = 1'b0;
  int            m_exp = 0;
  logic [CA-1:0] m_hc = '0;
  logic          m_rid = 1'b0;

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      m_cnt = 0; m_prio1 = 1'b0; m_hc = '0; m_rid = 1'b0;
    end else if (m_cnt == 0) begin
      if (req0_a && (!req1_a || !m_prio1)) begin
        m_word = data0_a; m_id = 1'b0; m_prio1 = 1'b1; m_cnt = 1;
      end else if (req1_a) begin
        m_word = data1_a; m_id = 1'b1; m_prio1 = 1'b0; m_cnt = 1;
      end
      if (m_cnt == 1) m_exp = sat(ideal_hits(32'(m_word), WA), CA);
    end else if (m_cnt == WA + 2) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == WA + 2) begin
        m_hc = CA'(m_exp); m_rid = m_id;
      end
    end
  end

  always @(negedge clk) begin
    logic e_g0, e_g1, e_bit;
    e_g0  = !rst_a && (m_cnt == 0) && req0_a && (!req1_a || !m_prio1);
    e_g1  = !rst_a && (m_cnt == 0) && req1_a && (!req0_a || m_prio1);
    e_bit = (m_cnt >= 2 && m_cnt <= WA + 1) ? m_word[WA-1-(m_cnt-2)] : 1'b0;
    check("gnt0", 32'(gnt0_a), 32'(e_g0));
    check("gnt1", 32'(gnt1_a), 32'(e_g1));
    check("busy", 32'(busy_a), 32'(m_cnt != 0));
    check("det_rst", 32'(det_rst_a), 32'(rst_a || m_cnt == 1));
    check("det_bit", 32'(det_bit_a), 32'(e_bit));
    check("done", 32'(done_a), 32'(m_cnt == WA + 2));
    check("hit_count", 32'(hit_count_a), 32'(m_hc));
    check("result_id", 32'(result_id_a), 32'(m_rid));
  end

  // Event logs for the directed scenarios.
  int g_cyc[$];
  bit g_id[$];
  int d_cyc[$];
  int d_hc[$];
  bit d_id[$];
  int r_cyc[$];
  always @(negedge clk) begin
    if (gnt0_a) begin g_cyc.push_back(cyc); g_id.push_back(1'b0); end
    if (gnt1_a) begin g_cyc.push_back(cyc); g_id.push_back(1'b1); end
    if (done_a) begin d_cyc.push_back(cyc); d_hc.push_back(int'(hit_count_a)); d_id.push_back(result_id_a); end
    if (det_rst_a && !rst_a) r_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan_a(input bit id, input logic [WA-1:0] d, input int exp_hits);
    int ng, nd, k;
    ng = g_cyc.size();
    nd = d_cyc.size();
    if (id) begin req1_a = 1'b1; data1_a = d; end
    else    begin req0_a = 1'b1; data0_a = d; end
    k = 0;
    while (g_cyc.size() == ng && k < 40) begin tick(); k++; end
    if (id) req1_a = 1'b0; else req0_a = 1'b0;
    if (g_cyc.size() == ng) begin check("scan_grant_timeout", 0, 1); return; end
    check("scan_grant_id", 32'(g_id[ng]), 32'(id));
    k = 0;
    while (d_cyc.size() == nd && k < 40) begin tick(); k++; end
    if (d_cyc.size() == nd) begin check("scan_done_timeout", 0, 1); return; end
    check("scan_det_rst_at_T+1", 32'(r_cyc[r_cyc.size()-1]), 32'(g_cyc[ng] + 1));
    check("scan_latency", 32'(d_cyc[nd] - g_cyc[ng]), 32'(WA + 2));
    check("scan_hit_count", 32'(d_hc[nd]), 32'(exp_hits));
    check("scan_result_id", 32'(d_id[nd]), 32'(id));
    tick();
  endtask

  initial begin
    int ng, nd, k, tg, td;

    check("model_hits_6A", 32'(ideal_hits(32'h6A, 8)), 3);
    check("model_hits_6A6A", 32'(ideal_hits(32'h6A6A, 16)), 6);
    check("model_sat_6_cnt2", 32'(sat(6, 2)), 3);

    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    check("reset_det_rst", 32'(det_rst_a), 1);
    check("reset_busy", 32'(busy_a), 0);
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();

    scan_a(1'b0, 8'h6A, 3);
    scan_a(1'b1, 8'h00, 0);
    scan_a(1'b1, 8'hFF, 0);
    scan_a(1'b0, 8'h5A, 2);

    // Both requesters held from reset: alternating grants, 11 cycles apart.
    rst_a = 1'b1;
    req0_a = 1'b1; req1_a = 1'b1; data0_a = 8'h6A; data1_a = 8'hA6;
    tick(); tick();
    rst_a = 1'b0;
    ng = g_cyc.size();
    k = 0;
    while (g_cyc.size() < ng + 4 && k < 80) begin tick(); k++; end
    req0_a = 1'b0; req1_a = 1'b0;
    if (g_cyc.size() < ng + 4) check("rr_timeout", 0, 1);
    else begin
      for (int i = 0; i < 4; i++) check("rr_order", 32'(g_id[ng+i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) check("rr_gap", 32'(g_cyc[ng+i] - g_cyc[ng+i-1]), 11);
    end
    repeat (WA + 4) tick();

    // req1 raised mid-scan is granted the cycle after done, never in it.
    ng = g_cyc.size();
    nd = d_cyc.size();
    req0_a = 1'b1; data0_a = 8'h6A;
    k = 0;
    while (g_cyc.size() == ng && k < 40) begin tick(); k++; end
    req0_a = 1'b0;
    repeat (3) tick();
    req1_a = 1'b1; data1_a = 8'h5A;
    k = 0;
    while (g_cyc.size() < ng + 2 && k < 40) begin tick(); k++; end
    req1_a = 1'b0;
    if (g_cyc.size() < ng + 2 || d_cyc.size() == nd) check("late_req_timeout", 0, 1);
    else begin
      check("late_req_id", 32'(g_id[ng+1]), 1);
      check("late_req_after_done", 32'(g_cyc[ng+1]), 32'(d_cyc[nd] + 1));
    end
    repeat (WA + 4) tick();
    if (d_cyc.size() < nd + 2) check("late_req_done_timeout", 0, 1);
    else check("late_req_hits", 32'(d_hc[nd+1]), 2);

    // Reset during SHIFT bit 5 aborts the scan and restores requester-0 priority.
    ng = g_cyc.size();
    req0_a = 1'b1; data0_a = 8'h6A;
    k = 0;
    while (g_cyc.size() == ng && k < 40) begin tick(); k++; end
    req0_a = 1'b0;
    if (g_cyc.size() == ng) check("abort_grant_timeout", 0, 1);
    else begin
      tg = g_cyc[ng];
      k = 0;
      while (cyc < tg + 7 && k < 40) begin tick(); k++; end
      rst_a = 1'b1; req0_a = 1'b1; req1_a = 1'b1;
      nd = d_cyc.size();
      #1;
      check("abort_gnt0", 32'(gnt0_a), 0);
      check("abort_gnt1", 32'(gnt1_a), 0);
      check("abort_busy", 32'(busy_a), 0);
      check("abort_done", 32'(done_a), 0);
      check("abort_det_bit", 32'(det_bit_a), 0);
      check("abort_hit_count", 32'(hit_count_a), 0);
      check("abort_result_id", 32'(result_id_a), 0);
      check("abort_det_rst", 32'(det_rst_a), 1);
      repeat (3) tick();
      rst_a = 1'b0;
      ng = g_cyc.size();
      k = 0;
      while (g_cyc.size() == ng && k < 20) begin tick(); k++; end
      req0_a = 1'b0; req1_a = 1'b0;
      check("abort_no_done", 32'(d_cyc.size()), 32'(nd));
      if (g_cyc.size() == ng) check("abort_regrant_timeout", 0, 1);
      else check("abort_first_grant", 32'(g_id[ng]), 0);
      repeat (WA + 6) tick();
      check("dropped_req_ignored", 32'(g_cyc.size()), 32'(ng + 1));
    end

    // Wide configuration: six ideal hits saturate a 2-bit count.
    req0_b = 1'b1; data0_b = 16'h6A6A;
    tg = -1;
    for (int i = 0; i < 40 && tg < 0; i++) begin
      @(negedge clk);
      if (gnt0_b) tg = cyc;
    end
    @(posedge clk); #1;
    req0_b = 1'b0;
    if (tg < 0) check("wide_grant_timeout", 0, 1);
    else begin
      td = -1;
      for (int i = 0; i < 40 && td < 0; i++) begin
        @(negedge clk);
        if (done_b) begin
          td = cyc;
          check("wide_hit_count", 32'(hit_count_b), 3);
          check("wide_result_id", 32'(result_id_b), 0);
        end
      end
      if (td < 0) check("wide_done_timeout", 0, 1);
      else check("wide_latency", 32'(td - tg), 32'(WB + 2));
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/seqdet_scheduler.md
SEQDET_SCHEDULER -- requirements
Module: seqdet_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of bits in each request word (4 to 32).
REQ-002 SHALL have parameter CNT_W, default 4, meaning the width of the hit count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports req0 and req1, input, 1 bit each: requester 0 and requester 1 request, held high until granted.
REQ-006 SHALL have ports data0 and data1, input, WIDTH bits each: the word to scan for each requester, valid while its request is high.
REQ-007 SHALL have ports gnt0 and gnt1, output, 1 bit each: a one-cycle grant pulse; data is captured in that cycle.
REQ-008 SHALL have port det_rst, output, 1 bit: reset to the serial pattern detector (0110/1010 detector).
REQ-009 SHALL have port det_bit, output, 1 bit: the serial bit driven to the detector.
REQ-010 SHALL have port det_hit, input, 1 bit: detector match output, combinationally valid in the same cycle as det_bit.
REQ-011 SHALL have port done, output, 1 bit: a one-cycle result-valid pulse.
REQ-012 SHALL have port result_id, output, 1 bit: the requester that owns the result.
REQ-013 SHALL have port hit_count, output, CNT_W bits: the number of matches found in the word.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement the states IDLE, CLEAR, SHIFT and REPORT.
REQ-016 IDLE: with no request, SHALL stay in IDLE with all outputs low.
REQ-017 IDLE with a request: SHALL grant one requester by round-robin, pulse its gnt, capture its data and ID, and go to CLEAR in the next cycle.
REQ-018 Round-robin: with both requests high, SHALL grant the requester not granted last; after reset, requester 0 has priority.
REQ-019 Grants SHALL be issued only from IDLE; gnt0 and gnt1 SHALL never be high together.
REQ-020 CLEAR: SHALL hold det_rst high for exactly one cycle, clear the bit index and hit counter, then go to SHIFT.
REQ-021 SHIFT: SHALL last exactly WIDTH cycles and drive det_bit from the captured word MSB first, one bit per cycle.
REQ-022 SHIFT: SHALL sample det_hit at each rising edge and increment the hit counter when it is high.
REQ-023 The hit counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 After the WIDTH-th bit, SHALL go to REPORT.
REQ-025 REPORT: SHALL hold done high for one cycle, with hit_count and result_id valid in that same cycle, then return to IDLE.
REQ-026 hit_count and result_id SHALL hold their values until the next REPORT.
REQ-027 Latency: for a grant in cycle T, CLEAR SHALL be in T+1, SHIFT in T+2 to T+WIDTH+1, and done in T+WIDTH+2.
REQ-028 A request arriving while busy SHALL wait for the next IDLE; a request dropped before grant SHALL be ignored.
REQ-029 A request high in the same cycle as done SHALL not be granted until the following IDLE cycle.
REQ-030 det_bit SHALL be 0 outside SHIFT.

Reset
REQ-031 While reset is high: state SHALL be IDLE; gnt0, gnt1, done, busy, det_bit, hit_count and result_id SHALL be 0; the round-robin pointer SHALL favour requester 0.
REQ-032 det_rst SHALL be high whenever reset is high.
REQ-033 Reset mid-scan SHALL abort the scan with no done pulse and no grant until reset deasserts.

Verification
REQ-034 req0 high, data0=8'h6A -> gnt0 pulse at T; det_rst high at T+1; done at T+10 with hit_count=3 and result_id=0.
REQ-035 req1 high, data1=8'h00, then 8'hFF -> each gives done with hit_count=0 and result_id=1.
REQ-036 req0 and req1 held high together from reset -> grant order 0, 1, 0, 1, with exactly 11 cycles between successive grants.
REQ-037 Reset asserted during SHIFT bit 5 -> all outputs 0 immediately; no done; det_rst high; first grant after reset goes to requester 0.
REQ-038 req1 raised during a requester-0 scan -> gnt1 issued in the first IDLE cycle after done, and not in the done cycle.
REQ-039 WIDTH=16, CNT_W=2, data0=16'h6A6A -> 6 ideal hits, so hit_count saturates at 3.
